// File: rtl/cmprs_pkg.sv
// Shared types and constants for the zero-word packet compressor.
// Default geometry, FSM/mode encodings and header layout live here.
package cmprs_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_DATA   = 8;

    // Nonzero mask occupies the low NUM_DATA bits of the header word.
    localparam int HDR_MASK_LSB = 0;

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        DRAIN  = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    typedef enum logic {
        COMPRESS = 1'b0,
        BYPASS   = 1'b1
    } mode_t;

endpackage

// File: rtl/cmprs_word_packer.sv
// Combinational compaction of one beat: header word (nonzero mask) followed
// by the nonzero words in ascending index order, plus the resulting word count.
module cmprs_word_packer
    import cmprs_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_DATA   = DEF_NUM_DATA,
    parameter int CW         = $clog2(2*NUM_DATA+1)
) (
    input  logic [DATA_WIDTH*NUM_DATA-1:0]     i_beat,
    output logic [(NUM_DATA+1)*DATA_WIDTH-1:0] o_words,
    output logic [CW-1:0]                      o_count
);

    logic [NUM_DATA-1:0]   w_mask;
    logic [DATA_WIDTH-1:0] w_hdr;

    always_comb begin
        logic [CW-1:0] idx;
        w_mask = '0;
        for (int i = 0; i < NUM_DATA; i++) begin
            w_mask[i] = |i_beat[i*DATA_WIDTH +: DATA_WIDTH];
        end
        w_hdr = '0;
        w_hdr[HDR_MASK_LSB +: NUM_DATA] = w_mask;
        o_words = '0;
        o_words[DATA_WIDTH-1:0] = w_hdr;
        idx = CW'(1);
        for (int i = 0; i < NUM_DATA; i++) begin
            if (w_mask[i]) begin
                o_words[idx*DATA_WIDTH +: DATA_WIDTH] = i_beat[i*DATA_WIDTH +: DATA_WIDTH];
                idx = idx + 1'b1;
            end
        end
        o_count = idx;
    end

endmodule

// File: rtl/zero_word_compressor.sv
// Zero-word packet compressor: per-beat mask header + nonzero words, repacked
// into full output beats; optional word statistics under CMPRS_STATS_EN.
module zero_word_compressor
    import cmprs_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_DATA   = DEF_NUM_DATA
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             wrt_en,
    input  logic [DATA_WIDTH*NUM_DATA-1:0]   data_in,
    input  logic                             tvalid_in,
    input  logic                             tlast_in,
    output logic                             tready_out,
    input  logic                             tready_in,
    output logic [DATA_WIDTH*NUM_DATA-1:0]   data_out,
    output logic                             tvalid_out,
    output logic                             tlast_out,
    output logic [DATA_WIDTH*NUM_DATA/8-1:0] tkeep,
    output logic [1:0]                       o_dbg_state
`ifdef CMPRS_STATS_EN
    ,
    output logic [31:0]                      stat_in_words,
    output logic [31:0]                      stat_out_words
`endif
);

    localparam int BW = DATA_WIDTH*NUM_DATA;
    localparam int WB = DATA_WIDTH/8;
    localparam int KB = BW/8;
    localparam int CW = $clog2(2*NUM_DATA+1);
    localparam logic [CW-1:0] N_W  = CW'(NUM_DATA);
    localparam logic [CW-1:0] N2_W = CW'(2*NUM_DATA);

    // Residual never exceeds NUM_DATA words, so only the low half is stored.
    logic [DATA_WIDTH-1:0] r_buf [NUM_DATA];
    logic [CW-1:0]         r_cnt;
    state_t                r_state;
    mode_t                 r_mode;
    logic                  r_in_pkt;

    logic [(NUM_DATA+1)*DATA_WIDTH-1:0] w_pk_words;
    logic [CW-1:0]         w_pk_k, w_c, w_m;
    logic [DATA_WIDTH-1:0] w_merged [2*NUM_DATA];
    logic [DATA_WIDTH-1:0] w_src [NUM_DATA];
    logic [BW-1:0]         w_data;
    logic [KB-1:0]         w_keep;
    mode_t                 w_mode;
    logic                  w_slot_free, w_accept, w_emit, w_last;

    cmprs_word_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_DATA   (NUM_DATA),
        .CW         (CW)
    ) u_packer (
        .i_beat  (data_in),
        .o_words (w_pk_words),
        .o_count (w_pk_k)
    );

    assign w_slot_free = !tvalid_out || tready_in;
    assign tready_out  = reset && (r_state == ACCEPT) && w_slot_free;
    assign w_accept    = tvalid_in && tready_out;
    assign w_mode      = r_in_pkt ? r_mode : (wrt_en ? COMPRESS : BYPASS);
    assign w_c         = r_cnt + w_pk_k;
    assign o_dbg_state = r_state;

    // Buffered residual followed by this beat's compacted words.
    always_comb begin
        for (int j = 0; j < 2*NUM_DATA; j++) begin
            w_merged[j] = '0;
            if (j < int'(r_cnt)) begin
                w_merged[j] = r_buf[j % NUM_DATA];
            end else if ((j - int'(r_cnt)) < int'(w_pk_k)) begin
                w_merged[j] = w_pk_words[(j - int'(r_cnt))*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        w_emit = 1'b0;
        w_last = 1'b0;
        w_m    = N_W;
        for (int j = 0; j < NUM_DATA; j++) w_src[j] = w_merged[j];
        case (r_state)
            ACCEPT: if (w_accept) begin
                if (w_mode == BYPASS) begin
                    w_emit = 1'b1;
                    w_last = tlast_in;
                    for (int j = 0; j < NUM_DATA; j++) w_src[j] = data_in[j*DATA_WIDTH +: DATA_WIDTH];
                end else if (tlast_in) begin
                    w_emit = 1'b1;
                    if (w_c <= N_W) begin
                        w_m    = w_c;
                        w_last = 1'b1;
                    end
                end else begin
                    w_emit = (w_c >= N_W);
                end
            end
            DRAIN: if (w_slot_free) begin
                w_emit = 1'b1;
                for (int j = 0; j < NUM_DATA; j++) w_src[j] = r_buf[j];
            end
            FLUSH: if (w_slot_free) begin
                w_emit = 1'b1;
                w_last = 1'b1;
                w_m    = r_cnt;
                for (int j = 0; j < NUM_DATA; j++) w_src[j] = r_buf[j];
            end
            default: ;
        endcase
        w_data = '0;
        for (int j = 0; j < NUM_DATA; j++) begin
            w_data[j*DATA_WIDTH +: DATA_WIDTH] = (j < int'(w_m)) ? w_src[j] : '0;
        end
        w_keep = '0;
        for (int b = 0; b < KB; b++) w_keep[b] = (b < int'(w_m)*WB);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ACCEPT;
            r_mode     <= COMPRESS;
            r_in_pkt   <= 1'b0;
            r_cnt      <= '0;
            for (int j = 0; j < NUM_DATA; j++) r_buf[j] <= '0;
            data_out   <= '0;
            tvalid_out <= 1'b0;
            tlast_out  <= 1'b0;
            tkeep      <= '0;
        end else begin
            if (w_emit) begin
                data_out   <= w_data;
                tkeep      <= w_keep;
                tlast_out  <= w_last;
                tvalid_out <= 1'b1;
            end else if (tready_in) begin
                tvalid_out <= 1'b0;
            end
            if (w_accept) begin
                r_in_pkt <= !tlast_in;
                r_mode   <= w_mode;
            end
            case (r_state)
                ACCEPT: if (w_accept && w_mode == COMPRESS) begin
                    if (!tlast_in && w_c < N_W) begin
                        for (int j = 0; j < NUM_DATA; j++) r_buf[j] <= w_merged[j];
                        r_cnt <= w_c;
                    end else if (tlast_in && w_c <= N_W) begin
                        r_cnt <= '0;
                    end else begin
                        for (int j = 0; j < NUM_DATA; j++) r_buf[j] <= w_merged[j+NUM_DATA];
                        r_cnt <= w_c - N_W;
                        if (tlast_in)         r_state <= FLUSH;
                        else if (w_c == N2_W) r_state <= DRAIN;
                    end
                end
                DRAIN, FLUSH: if (w_slot_free) begin
                    r_cnt   <= '0;
                    r_state <= ACCEPT;
                end
                default: r_state <= ACCEPT;
            endcase
        end
    end

`ifdef CMPRS_STATS_EN
    logic [31:0] r_stat_in, r_stat_out;
    logic [32:0] w_in_sum, w_out_sum;

    assign w_in_sum  = {1'b0, r_stat_in}  + (w_accept ? 33'(NUM_DATA) : 33'd0);
    assign w_out_sum = {1'b0, r_stat_out} + (w_emit ? 33'(w_m) : 33'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stat_in  <= '0;
            r_stat_out <= '0;
        end else begin
            r_stat_in  <= w_in_sum[32]  ? '1 : w_in_sum[31:0];
            r_stat_out <= w_out_sum[32] ? '1 : w_out_sum[31:0];
        end
    end

    assign stat_in_words  = r_stat_in;
    assign stat_out_words = r_stat_out;
`endif

endmodule
